// File: rtl/snn_lif_core.sv
// Leaky-integrate-and-fire layer: N_IN spike inputs fully connected to N_OUT neurons, with its own config registers.
// Optional per-neuron fire counters at 0x80+j when SNN_SPIKE_CNT_EN is defined.
module snn_lif_core #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int W_W   = 8,
    parameter int V_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic             cfg_re,
    input  logic [7:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    output logic [7:0]       cfg_rdata,
    output logic             cfg_nack,
    input  logic             step,
    input  logic [N_IN-1:0]  in_spikes,
    output logic             busy,
    output logic             done,
    output logic [N_OUT-1:0] out_spikes
);
    localparam int ROW_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int W_BASE = 8'h10;
    localparam int C_BASE = 8'h80;

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

    state_t            state;
    logic [ROW_W-1:0]  row;
    logic [N_IN-1:0]   spk_lat;
    logic [W_W-1:0]    thr, leak, refr;
    logic [W_W-1:0]    weight  [N_IN][N_OUT];
    logic [V_W-1:0]    v       [N_OUT];
    logic [W_W-1:0]    ref_cnt [N_OUT];
    logic [V_W-1:0]    v_leak  [N_OUT];
`ifdef SNN_SPIKE_CNT_EN
    logic [7:0]        fire_cnt [N_OUT];
`endif

    logic              addr_hit;
    logic [7:0]        rd_val;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        addr_hit = 1'b0;
        rd_val   = '0;
        if (cfg_addr == 8'h00) begin addr_hit = 1'b1; rd_val = thr;  end
        if (cfg_addr == 8'h01) begin addr_hit = 1'b1; rd_val = leak; end
        if (cfg_addr == 8'h02) begin addr_hit = 1'b1; rd_val = refr; end
        for (int i = 0; i < N_IN; i++)
            for (int j = 0; j < N_OUT; j++)
                if (cfg_addr == 8'(W_BASE + i*N_OUT + j)) begin
                    addr_hit = 1'b1;
                    rd_val   = weight[i][j];
                end
`ifdef SNN_SPIKE_CNT_EN
        for (int j = 0; j < N_OUT; j++)
            if (cfg_addr == 8'(C_BASE + j)) begin
                addr_hit = 1'b1;
                rd_val   = fire_cnt[j];
            end
`endif
    end

    // Leak is applied after this step's accumulation, clamped at zero.
    always_comb begin
        for (int j = 0; j < N_OUT; j++)
            v_leak[j] = (v[j] > V_W'(leak)) ? v[j] - V_W'(leak) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            spk_lat    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_spikes <= '0;
            cfg_rdata  <= '0;
            cfg_nack   <= 1'b0;
            thr        <= 8'd255;
            leak       <= '0;
            refr       <= '0;
            // NOTE: the weight file is reset explicitly; it is a small register array, not a RAM macro.
            for (int i = 0; i < N_IN; i++)
                for (int j = 0; j < N_OUT; j++)
                    weight[i][j] <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                v[j]       <= '0;
                ref_cnt[j] <= '0;
`ifdef SNN_SPIKE_CNT_EN
                fire_cnt[j] <= '0;
`endif
            end
        end else begin
            done     <= 1'b0;
            cfg_nack <= 1'b0;
            if (cfg_re)
                cfg_rdata <= rd_val;

            // Writes commit only in IDLE, so they never collide with UPDATE-side counter increments.
            if (cfg_we) begin
                if (busy || !addr_hit) begin
                    cfg_nack <= 1'b1;
                end else begin
                    if (cfg_addr == 8'h00) thr  <= cfg_wdata;
                    if (cfg_addr == 8'h01) leak <= cfg_wdata;
                    if (cfg_addr == 8'h02) refr <= cfg_wdata;
                    for (int i = 0; i < N_IN; i++)
                        for (int j = 0; j < N_OUT; j++)
                            if (cfg_addr == 8'(W_BASE + i*N_OUT + j))
                                weight[i][j] <= cfg_wdata;
`ifdef SNN_SPIKE_CNT_EN
                    for (int j = 0; j < N_OUT; j++)
                        if (cfg_addr == 8'(C_BASE + j))
                            fire_cnt[j] <= '0;
`endif
                end
            end

            case (state)
                IDLE: begin
                    if (step) begin
                        spk_lat <= in_spikes;
                        row     <= '0;
                        busy    <= 1'b1;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    for (int j = 0; j < N_OUT; j++)
                        if (spk_lat[row] && ref_cnt[j] == '0)
                            v[j] <= v[j] + V_W'(weight[row][j]);
                    if (row == ROW_W'(N_IN - 1))
                        state <= UPDATE;
                    else
                        row <= row + 1'b1;
                end
                UPDATE: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        if (ref_cnt[j] != '0) begin
                            ref_cnt[j]    <= ref_cnt[j] - 1'b1;
                            v[j]          <= '0;
                            out_spikes[j] <= 1'b0;
                        end else if (v_leak[j] >= V_W'(thr)) begin
                            v[j]          <= '0;
                            ref_cnt[j]    <= refr;
                            out_spikes[j] <= 1'b1;
`ifdef SNN_SPIKE_CNT_EN
                            if (fire_cnt[j] != 8'd255)
                                fire_cnt[j] <= fire_cnt[j] + 1'b1;
`endif
                        end else begin
                            v[j]          <= v_leak[j];
                            out_spikes[j] <= 1'b0;
                        end
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_lif_core.sv
// Directed self-checking bench for snn_lif_core (N_IN=4, N_OUT=3); counter checks follow SNN_SPIKE_CNT_EN.
module tb_snn_lif_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0, cfg_re = 1'b0;
    logic [7:0] cfg_addr = '0, cfg_wdata = '0;
    logic [7:0] cfg_rdata;
    logic       cfg_nack;
    logic       step = 1'b0;
    logic [3:0] in_spikes = '0;
    logic       busy, done;
    logic [2:0] out_spikes;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] w_tab [12];

    snn_lif_core #(.N_IN(4), .N_OUT(3), .W_W(8), .V_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .cfg_nack(cfg_nack),
        .step(step), .in_spikes(in_spikes),
        .busy(busy), .done(done), .out_spikes(out_spikes)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [7:0] data, output logic nack);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
        nack = cfg_nack;
    endtask

    task automatic cfg_read(input logic [7:0] addr, output logic [7:0] data);
        cfg_re = 1'b1; cfg_addr = addr;
        tick();
        cfg_re = 1'b0;
        data = cfg_rdata;
    endtask

    task automatic setup(input logic [7:0] t, input logic [7:0] l, input logic [7:0] r);
        logic n;
        cfg_write(8'h00, t, n);
        cfg_write(8'h01, l, n);
        cfg_write(8'h02, r, n);
        for (int i = 0; i < 12; i++)
            cfg_write(8'(16 + i), w_tab[i], n);
    endtask

    // Returns out_spikes at done and the cycle count from step to done (20 = timed out).
    task automatic run_step(input logic [3:0] spk, output logic [2:0] outs, output int lat);
        step = 1'b1; in_spikes = spk;
        tick();
        step = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        outs = out_spikes;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        apply_reset();
        n_chk++; if (out_spikes !== 3'b000) begin n_err++; $display("FAIL reset_out got %b want 000", out_spikes); end
        n_chk++; if ({busy, done, cfg_nack} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {busy, done, cfg_nack}); end
        n_chk++; if (cfg_rdata !== 8'd0) begin n_err++; $display("FAIL reset_rdata got %0d want 0", cfg_rdata); end
        cfg_read(8'h00, rd);
        n_chk++; if (rd !== 8'd255) begin n_err++; $display("FAIL reset_thr got %0d want 255", rd); end
        cfg_read(8'h02, rd);
        n_chk++; if (rd !== 8'd0) begin n_err++; $display("FAIL reset_refr got %0d want 0", rd); end
        cfg_read(8'h1B, rd);
        n_chk++; if (rd !== 8'd0) begin n_err++; $display("FAIL reset_w32 got %0d want 0", rd); end
    endtask

    task automatic test_config();
        logic [7:0] rd;
        logic n;
        cfg_write(8'h00, 8'd50, n);
        n_chk++; if (n !== 1'b0) begin n_err++; $display("FAIL cfg_write_ack got nack=%b want 0", n); end
        setup(8'd50, 8'd5, 8'd10);
        cfg_read(8'h01, rd);
        n_chk++; if (rd !== 8'd5) begin n_err++; $display("FAIL cfg_leak got %0d want 5", rd); end
        cfg_read(8'h02, rd);
        n_chk++; if (rd !== 8'd10) begin n_err++; $display("FAIL cfg_refr got %0d want 10", rd); end
        cfg_read(8'h14, rd);
        n_chk++; if (rd !== 8'd25) begin n_err++; $display("FAIL cfg_w11 got %0d want 25", rd); end
        cfg_read(8'h7F, rd);
        n_chk++; if (rd !== 8'd0) begin n_err++; $display("FAIL cfg_unmapped_rd got %0d want 0", rd); end
    endtask

    task automatic test_integrate();
        logic [2:0] o;
        int lat;
        run_step(4'b0001, o, lat);
        n_chk++; if (o !== 3'b000) begin n_err++; $display("FAIL int_step1 got %b want 000", o); end
        n_chk++; if (lat != 6) begin n_err++; $display("FAIL int_latency got %0d want 6", lat); end
        run_step(4'b0001, o, lat);
        n_chk++; if (o !== 3'b001) begin n_err++; $display("FAIL int_step2 got %b want 001", o); end
        // v1 = 30 + 25 - 5 reaches threshold; neuron 0 is refractory.
        run_step(4'b0010, o, lat);
        n_chk++; if (o !== 3'b010) begin n_err++; $display("FAIL int_step3 got %b want 010", o); end
    endtask

    task automatic test_latency();
        apply_reset();
        in_spikes = 4'b0000;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step = (k == 2);
            n_chk++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++; $display("FAIL lat_busy t+%0d got busy=%b done=%b want 1 0", k, busy, done);
            end
            tick();
        end
        step = 1'b0;
        n_chk++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL lat_done got busy/done=%b want 01", {busy, done}); end
        tick();
        n_chk++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL lat_after got busy/done=%b want 00", {busy, done}); end
    endtask

    task automatic test_nack();
        logic [7:0] rd;
        logic n;
        int lat;
        setup(8'd50, 8'd5, 8'd10);
        step = 1'b1; in_spikes = 4'b0000;
        tick();
        step = 1'b0;
        cfg_write(8'h00, 8'd99, n);
        n_chk++; if (n !== 1'b1) begin n_err++; $display("FAIL nack_busy got %b want 1", n); end
        lat = 0;
        while (!done && lat < 20) begin tick(); lat++; end
        n_chk++; if (done !== 1'b1) begin n_err++; $display("FAIL nack_done_timeout got done=%b want 1", done); end
        cfg_read(8'h00, rd);
        n_chk++; if (rd !== 8'd50) begin n_err++; $display("FAIL nack_thr_kept got %0d want 50", rd); end
        cfg_write(8'h7F, 8'd1, n);
        n_chk++; if (n !== 1'b1) begin n_err++; $display("FAIL nack_unmapped got %b want 1", n); end
    endtask

    task automatic test_refractory();
        logic [2:0] o;
        logic [2:0] exp_tab [6];
        int lat;
        exp_tab[0] = 3'b000; exp_tab[1] = 3'b111; exp_tab[2] = 3'b000;
        exp_tab[3] = 3'b000; exp_tab[4] = 3'b000; exp_tab[5] = 3'b111;
        apply_reset();
        setup(8'd50, 8'd5, 8'd2);
        for (int s = 0; s < 6; s++) begin
            run_step(4'b0011, o, lat);
            n_chk++;
            if (o !== exp_tab[s]) begin n_err++; $display("FAIL refr_step%0d got %b want %b", s, o, exp_tab[s]); end
        end
    endtask

    task automatic test_thr0();
        logic [2:0] o;
        logic n;
        int lat;
        apply_reset();
        setup(8'd50, 8'd0, 8'd0);
        // Write and step in the same IDLE cycle: the new threshold must be used.
        step = 1'b1; in_spikes = 4'b0000;
        cfg_we = 1'b1; cfg_addr = 8'h00; cfg_wdata = 8'd0;
        tick();
        step = 1'b0; cfg_we = 1'b0;
        n = cfg_nack;
        n_chk++; if (n !== 1'b0) begin n_err++; $display("FAIL thr0_simul_nack got %b want 0", n); end
        lat = 1;
        while (!done && lat < 20) begin tick(); lat++; end
        n_chk++; if (out_spikes !== 3'b111) begin n_err++; $display("FAIL thr0_step1 got %b want 111", out_spikes); end
        run_step(4'b0000, o, lat);
        n_chk++; if (o !== 3'b111) begin n_err++; $display("FAIL thr0_step2 got %b want 111", o); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        int pulses;
        step = 1'b1; in_spikes = 4'b1111;
        tick();
        step = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        n_chk++; if (pulses != 0) begin n_err++; $display("FAIL rstmid_done got %0d pulses want 0", pulses); end
        n_chk++; if ({busy, out_spikes} !== 4'b0000) begin n_err++; $display("FAIL rstmid_state got %b want 0000", {busy, out_spikes}); end
        cfg_read(8'h00, rd);
        n_chk++; if (rd !== 8'd255) begin n_err++; $display("FAIL rstmid_thr got %0d want 255", rd); end
    endtask

    task automatic test_counters();
        logic [7:0] rd;
        logic n;
`ifdef SNN_SPIKE_CNT_EN
        logic [2:0] o;
        int lat, bad;
        apply_reset();
        setup(8'd0, 8'd0, 8'd0);
        bad = 0;
        for (int s = 0; s < 300; s++) begin
            run_step(4'b0000, o, lat);
            if (o !== 3'b111 || lat != 6) bad++;
        end
        n_chk++; if (bad != 0) begin n_err++; $display("FAIL cnt_steps got %0d bad steps want 0", bad); end
        cfg_read(8'h80, rd);
        n_chk++; if (rd !== 8'd255) begin n_err++; $display("FAIL cnt_sat got %0d want 255", rd); end
        cfg_write(8'h80, 8'd7, n);
        n_chk++; if (n !== 1'b0) begin n_err++; $display("FAIL cnt_clr_nack got %b want 0", n); end
        cfg_read(8'h80, rd);
        n_chk++; if (rd !== 8'd0) begin n_err++; $display("FAIL cnt_cleared got %0d want 0", rd); end
        cfg_read(8'h81, rd);
        n_chk++; if (rd !== 8'd255) begin n_err++; $display("FAIL cnt_other got %0d want 255", rd); end
`else
        cfg_read(8'h80, rd);
        n_chk++; if (rd !== 8'd0) begin n_err++; $display("FAIL nocnt_read got %0d want 0", rd); end
        cfg_write(8'h80, 8'd1, n);
        n_chk++; if (n !== 1'b1) begin n_err++; $display("FAIL nocnt_write_nack got %b want 1", n); end
`endif
    endtask

    initial begin
        w_tab[0] = 8'd30; w_tab[1]  = 8'd20; w_tab[2]  = 8'd10;
        w_tab[3] = 8'd15; w_tab[4]  = 8'd25; w_tab[5]  = 8'd35;
        w_tab[6] = 8'd40; w_tab[7]  = 8'd1;  w_tab[8]  = 8'd2;
        w_tab[9] = 8'd3;  w_tab[10] = 8'd4;  w_tab[11] = 8'd5;
        test_reset();
        test_config();
        test_integrate();
        test_latency();
        test_nack();
        test_refractory();
        test_thr0();
        test_reset_mid();
        test_counters();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
